// File: rtl/down_counter_param_if.sv
// Control and status bundle for the parametrised down-counter.
// The master drives load/decrement/step/mode/initial_value; the slave returns count and flags.
interface down_counter_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              load;
  logic              decrement;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  initial_value;
  logic [WIDTH-1:0]  count;
  logic              zero;
  logic              underflow;
  logic              busy;

  modport master (
    output load, decrement, step, mode, initial_value,
    input  count, zero, underflow, busy
  );

  modport slave (
    input  load, decrement, step, mode, initial_value,
    output count, zero, underflow, busy
  );
endinterface

// File: rtl/down_counter_param.sv
// Loadable down-counter with run-time underflow modes: wrap, saturate, auto-reload, one-shot.
// count, underflow and busy are registered; zero is decoded combinationally from count.
module down_counter_param #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  down_counter_param_if.slave      bus
);

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_SAT    = 2'b01;
  localparam logic [1:0] MODE_RELOAD = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             underflow_q, underflow_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] step_ext;
  logic [WIDTH:0]   diff;
  logic             borrow;

  // Subtract at WIDTH+1 bits so the top bit carries the borrow.
  always_comb begin
    step_ext = WIDTH'(bus.step);
    diff     = {1'b0, count_q} - {1'b0, step_ext};
    borrow   = diff[WIDTH];
  end

  always_comb begin
    count_d     = count_q;
    reload_d    = reload_q;
    underflow_d = 1'b0;
    busy_d      = busy_q && (bus.mode == MODE_ONESHOT);

    if (bus.load) begin
      count_d  = bus.initial_value;
      reload_d = bus.initial_value;
      busy_d   = (bus.mode == MODE_ONESHOT) && (bus.initial_value != '0);
    end else if (bus.decrement) begin
      if ((bus.mode == MODE_ONESHOT) && !busy_q) begin
        count_d = count_q;
      end else if (bus.step == '0) begin
        count_d = count_q;
      end else if (!borrow) begin
        count_d = diff[WIDTH-1:0];
        if ((bus.mode == MODE_ONESHOT) && (diff[WIDTH-1:0] == '0)) begin
          busy_d = 1'b0;
        end
      end else begin
        underflow_d = 1'b1;
        case (bus.mode)
          MODE_WRAP:    count_d = diff[WIDTH-1:0];
          MODE_SAT:     count_d = '0;
          MODE_RELOAD:  count_d = reload_q;
          MODE_ONESHOT: begin
            count_d = '0;
            busy_d  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      reload_q    <= '0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.zero      = (count_q == '0);
  assign bus.underflow = underflow_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_down_counter_param.sv
// Scoreboard bench for down_counter_param: a driver issues cycles and queues the expected
// post-edge state from an arithmetic model; a monitor compares after every rising edge.
module tb_down_counter_param;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam int MODULUS = 1 << W;

  logic clk;
  logic reset;

  down_counter_param_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  down_counter_param #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int c;
    int u;
    int b;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int m_count, m_reload, m_busy, m_uf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  task automatic model(input int ld, input int dec, input int st, input int md, input int iv);
    m_uf = 0;
    if (ld != 0) begin
      m_count  = iv;
      m_reload = iv;
      m_busy   = (md == 3 && iv != 0) ? 1 : 0;
    end else begin
      int was_busy;
      was_busy = m_busy;
      if (md != 3) m_busy = 0;
      if (dec != 0 && !(md == 3 && was_busy == 0) && st != 0) begin
        if (st <= m_count) begin
          m_count = m_count - st;
          if (md == 3 && m_count == 0) m_busy = 0;
        end else begin
          m_uf = 1;
          case (md)
            0: m_count = (m_count - st + MODULUS) % MODULUS;
            1: m_count = 0;
            2: m_count = m_reload;
            default: begin
              m_count = 0;
              m_busy  = 0;
            end
          endcase
        end
      end
    end
  endtask

  task automatic cyc(input int ld, input int dec, input int st, input int md, input int iv);
    exp_t e;
    @(negedge clk);
    bus.load          = ld[0];
    bus.decrement     = dec[0];
    bus.step          = SW'(st);
    bus.mode          = md[1:0];
    bus.initial_value = W'(iv);
    model(ld, dec, st, md, iv);
    e.c = m_count;
    e.u = m_uf;
    e.b = m_busy;
    q.push_back(e);
  endtask

  // Monitor: every edge produces one registered result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", int'(bus.count), e.c);
        chk("zero", int'(bus.zero), (e.c == 0) ? 1 : 0);
        chk("underflow", int'(bus.underflow), e.u);
        chk("busy", int'(bus.busy), e.b);
      end
    end
  end

  initial begin
    int md, ld, dec, st, iv, waited;
    bus.load = 1'b0; bus.decrement = 1'b0; bus.step = '0;
    bus.mode = 2'b01; bus.initial_value = '0;
    m_count = 0; m_reload = 0; m_busy = 0; m_uf = 0;
    reset = 1'b1;
    #2;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_zero", int'(bus.zero), 1);
    chk("rst_underflow", int'(bus.underflow), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;

    // Load and count down a little, then reset asynchronously mid-count.
    cyc(1, 0, 0, 1, 8'h10);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 2, 1, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_count", int'(bus.count), 0);
    chk("async_rst_zero", int'(bus.zero), 1);
    chk("async_rst_underflow", int'(bus.underflow), 0);
    m_count = 0; m_reload = 0; m_busy = 0; m_uf = 0;
    bus.load = 1'b0; bus.decrement = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 0, 0, 1, 8'h10);

    // Wrap.
    cyc(1, 0, 0, 0, 8'h03);
    cyc(0, 1, 5, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Saturate versus reaching zero exactly.
    cyc(1, 0, 0, 1, 8'h06);
    cyc(0, 1, 3, 1, 0);
    cyc(0, 1, 3, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Auto-reload periodic tick.
    cyc(1, 0, 0, 2, 8'h04);
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 2, 0);

    // One-shot.
    cyc(1, 0, 0, 3, 8'h02);
    cyc(0, 1, 1, 3, 0);
    cyc(0, 1, 1, 3, 0);
    cyc(0, 1, 1, 3, 0);
    cyc(0, 1, 7, 3, 0);
    cyc(1, 0, 0, 3, 8'h00);

    // Priority, zero step, leaving one-shot while busy.
    cyc(1, 1, 3, 0, 8'h20);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 3, 8'h05);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 2, 3, 0);

    // Randomised traffic with sticky modes.
    md = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) md = int'($urandom_range(3));
      ld  = ($urandom_range(7) == 0) ? 1 : 0;
      dec = ($urandom_range(3) != 0) ? 1 : 0;
      st  = int'($urandom_range(15));
      iv  = ($urandom_range(1) == 1) ? int'($urandom_range(20)) : int'($urandom_range(255));
      cyc(ld, dec, st, md, iv);
    end
    cyc(0, 0, 0, md, 0);

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
